// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and default sizes for the register dump reader.
// Provides the FSM state enum and the default WIDTH / NREGS constants.
package reg_dump_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_CSUM = 2'd3
    } dump_state_t;

endpackage

// File: rtl/dump_idx_counter.sv
// dump_idx_counter: register index walker for the dump reader.
// Ports: clk, rst (async, active high), i_clr, i_inc -> o_idx, o_last (idx==NREGS-1).
module dump_idx_counter #(
    parameter  int NREGS = 32,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [IDX_W-1:0] r_idx;
    logic             w_last;

    assign w_last = (r_idx == IDX_W'(NREGS - 1));

    // Increment saturates at the terminal index so a dump never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc && !w_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = w_last;

endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks registers 0..NREGS-1 over one read port and streams
// each word out as {out_data, out_idx, out_last} on a valid/ready handshake.
// Ports: clk, rst, start, abort -> busy, done; rf_addr/rf_data read port;
// out_valid/out_ready/out_data/out_idx/out_last stream.
// Option: REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
import reg_dump_pkg::*;

module reg_dump_reader #(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREGS = DEF_NREGS,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rf_addr,
    input  logic [WIDTH-1:0] rf_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    logic [WIDTH-1:0] r_acc;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    dump_state_t      r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done;

    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_hs;
    logic             w_clr;
    logic             w_inc;

    assign w_hs  = r_out_valid & out_ready;
    assign w_clr = (r_state == ST_IDLE) & start & ~abort;
    assign w_inc = (r_state == ST_SEND) & w_hs & ~abort;

    dump_idx_counter #(
        .NREGS (NREGS)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_acc       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            // Abort wins over a same-cycle handshake.
            if (abort && r_state != ST_IDLE) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state <= ST_READ;
`ifdef REG_DUMP_CHECKSUM_EN
                            r_acc   <= '0;
`endif
                        end
                    end
                    ST_READ: begin
                        r_out_data  <= rf_data;
                        r_out_idx   <= w_idx;
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_last & ~CSUM_EN;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_acc       <= r_acc ^ rf_data;
`endif
                        r_state     <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (w_hs) begin
                            if (!w_last) begin
                                r_out_valid <= 1'b0;
                                r_state     <= ST_READ;
                            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                                // Valid stays high: checksum word follows directly.
                                r_out_data <= r_acc;
                                r_out_idx  <= '0;
                                r_out_last <= 1'b1;
                                r_state    <= ST_CSUM;
`else
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= ST_IDLE;
`endif
                            end
                        end
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    ST_CSUM: begin
                        if (w_hs) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign rf_addr   = w_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: table-driven and randomized bench for reg_dump_reader.
// Expected stream is built from a snapshot of the register bank at start.
module tb_reg_dump_reader;

    localparam int N = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef struct {
        int ready_mode;   // 0: always ready, 1: random ready
        int stall_idx;    // hold ready low while this idx is valid
        int stall_len;
        int abort_idx;    // abort while this word is valid (-1: none)
        int restart_idx;  // pulse start while this word is valid (-1: none)
        int exp_words;
        int exp_done;
        int exp_lat;      // negedge count from start drive to done (-1: skip)
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, out_valid, out_last;
    logic [4:0]  rf_addr, out_idx;
    logic [31:0] rf_data, out_data;
    logic [31:0] bank [N];

    int n_cmp = 0;
    int n_err = 0;

    assign rf_data = bank[rf_addr];

    always #5 clk = ~clk;

    reg_dump_reader #(.WIDTH(32), .NREGS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) bank[i] = 32'h1000_0000 + i;
    endtask

    task automatic run_dump(input vec_t v, output int words,
                            output int got_done, output int lat,
                            output int first_v);
        logic [31:0] ed[$];
        int          ei[$];
        bit          el[$];
        logic [31:0] cs = '0;
        bit exp_done_next = 0, done_seen = 0, abort_seen = 0;
        bit prev_wait = 0, restarted = 0, finished = 0;
        int stall = v.stall_len;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        for (int i = 0; i < N; i++) begin
            ed.push_back(bank[i]);
            ei.push_back(i);
            el.push_back(i == N - 1 && CS == 0);
            cs ^= bank[i];
        end
        if (CS != 0) begin
            ed.push_back(cs);
            ei.push_back(0);
            el.push_back(1'b1);
        end
        words = 0; got_done = 0; lat = -1; first_v = -1;
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b0;
        out_ready = (v.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int it = 0; it < 600 && !finished; it++) begin
            @(negedge clk);
            if (first_v < 0 && out_valid) first_v = it;
            if (abort_seen) begin
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                finished = 1;
            end else if (done_seen) begin
                check("done_pulse_len", done, 0);
                finished = 1;
            end else begin
                if (exp_done_next) begin
                    check("done", done, 1);
                    check("busy_after_done", busy, 0);
                    got_done = done;
                    lat = it;
                    done_seen = 1;
                end else begin
                    check("no_early_done", done, 0);
                end
                if (prev_wait) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, pd);
                    check("hold_idx", out_idx, pi);
                    check("hold_last", out_last, pl);
                end
                prev_wait = out_valid && !out_ready && !abort;
                pd = out_data; pi = out_idx; pl = out_last;
                if (abort) begin
                    abort_seen = 1;
                end else if (out_valid && out_ready) begin
                    check("word_expected", ed.size() != 0, 1);
                    if (ed.size() != 0) begin
                        check("out_idx", out_idx, ei[0]);
                        check("out_data", out_data, ed[0]);
                        check("out_last", out_last, el[0]);
                        void'(ed.pop_front());
                        void'(el.pop_front());
                        // Rewrite an already captured register: must not show up.
                        bank[$urandom_range(0, ei[0])] = $urandom;
                        void'(ei.pop_front());
                        words++;
                        if (ed.size() == 0) exp_done_next = 1;
                    end
                end
            end
            if (!finished) begin
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                out_ready = (v.ready_mode == 0) ? 1'b1
                                                : 1'($urandom_range(0, 1));
                if (v.restart_idx >= 0 && !restarted && out_valid &&
                    int'(out_idx) == v.restart_idx) begin
                    start = 1'b1;
                    restarted = 1;
                end
                if (stall > 0 && out_valid && int'(out_idx) == v.stall_idx) begin
                    out_ready = 1'b0;
                    stall--;
                end
                if (v.abort_idx >= 0 && out_valid && words == v.abort_idx) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                end
            end
        end
        check("dump_timeout", finished, 1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int w, d, l, f;
        bit found;
        vecs[0] = '{0, -1, 0, -1, -1, N + CS, 1, 65 + CS};
        vecs[1] = '{0,  7, 5, -1, -1, N + CS, 1, 70 + CS};
        vecs[2] = '{0, -1, 0, 10, -1, 10, 0, -1};
        vecs[3] = '{0, -1, 0, -1,  3, N + CS, 1, 65 + CS};
        vecs[4] = '{1, -1, 0, -1, -1, N + CS, 1, -1};
        vecs[5] = '{1,  7, 3, 20, -1, 20, 0, -1};

        load_ramp();
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_done", done, 0);
        check("rst_addr", rf_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);

        // Abort alone, then start with abort, must both leave IDLE untouched.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        @(posedge clk); #1;
        check("start_abort_valid", out_valid, 0);

        for (int k = 0; k < 6; k++) begin
            load_ramp();
            run_dump(vecs[k], w, d, l, f);
            check($sformatf("v%0d_words", k), w, vecs[k].exp_words);
            check($sformatf("v%0d_done", k), d, vecs[k].exp_done);
            if (vecs[k].exp_lat >= 0)
                check($sformatf("v%0d_latency", k), l, vecs[k].exp_lat);
            if (vecs[k].ready_mode == 0)
                check($sformatf("v%0d_first_valid", k), f, 2);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) bank[i] = $urandom;
            run_dump(vecs[4], w, d, l, f);
            check("rand_words", w, N + CS);
            check("rand_done", d, 1);
        end

        for (int i = 0; i < N; i++) bank[i] = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
        run_dump(vecs[0], w, d, l, f);
        check("ones_words", w, N + CS);

        // Asynchronous reset in the middle of a dump.
        load_ramp();
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (out_valid && out_idx == 5'd20) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reach_idx20", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_idx", out_idx, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_addr", rf_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_valid, 0);
        load_ramp();
        run_dump(vecs[0], w, d, l, f);
        check("post_rst_words", w, N + CS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the integer register bank: on a start pulse it walks register indices 0..NREGS-1 through one read port of the register unit, captures each word and presents it on a valid/ready stream tagged with its index. It sits beside the register unit, owns one read-address port, and feeds the debug/trace link. It performs no writes; register contents are never disturbed.

## Interface
- WIDTH, 32, data word width of the register bank
- NREGS, 32, number of registers dumped (power of two); IDX_W = $clog2(NREGS) is derived, not overridable

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next edge
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after final word handshake
- rf_addr  out  IDX_W  read address to register unit (combinational read port)
- rf_data  in  WIDTH  read data, valid in the same cycle as rf_addr
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  captured register word
- out_idx  out  IDX_W  index of out_data
- out_last  out  1  marks final word of the dump

## Operation
- States: IDLE, READ, SEND, CSUM (CSUM only with REG_DUMP_CHECKSUM_EN).
- IDLE: start=1 -> idx<=0, accumulator<=0, go READ. start while busy is ignored.
- READ (1 cycle): rf_addr=idx; at edge capture out_data<=rf_data, out_idx<=idx, out_valid<=1, out_last<=(idx==NREGS-1 and no checksum); go SEND.
- SEND: out_valid=1, out_data/out_idx/out_last held stable until out_valid&out_ready.
  - On handshake with idx<NREGS-1: idx<=idx+1, out_valid<=0, go READ.
  - On handshake with idx==NREGS-1: go CSUM (macro on) or IDLE with done pulse (macro off).
- rf_addr always drives idx (no glitch outside READ); idx never wraps within a dump.
- Data is sampled per register at its READ cycle; writes to a register after its capture are not reflected.
- abort (any non-IDLE state): next edge -> IDLE, out_valid=0, out_last=0, no done pulse; abort has priority over handshake in the same cycle.
- abort in IDLE has no effect; start and abort together in IDLE -> stay IDLE.

## Timing
- Reset: state IDLE, idx=0, rf_addr=0, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, accumulator=0.
- start sampled at edge N -> READ in cycle N+1 -> out_valid high from cycle N+2.
- Steady-state throughput with out_ready=1: one word per 2 cycles; full dump of 32 words = 64 cycles after start, done at cycle after last handshake.
- out_ready may be high before out_valid; only out_valid&out_ready counts.
- Reset asserted mid-dump: all outputs to reset values immediately (asynchronous).

## Configuration
- REG_DUMP_CHECKSUM_EN defined: accumulator XORs every captured word; after the NREGS-1 handshake, CSUM presents out_data=XOR of all words, out_idx=0, out_last=1; its handshake -> IDLE, done pulse. Word NREGS-1 then has out_last=0.
- Undefined: no accumulator, no CSUM state; word NREGS-1 carries out_last=1.

## Structure
- Package reg_dump_pkg: state enum (IDLE, READ, SEND, CSUM), default WIDTH/NREGS constants.
- One sub-module natural: dump_idx_counter (clear, increment, terminal-count flag idx==NREGS-1).
- FSM, capture register and accumulator stay in the top module.

## Test plan
- Bank preloaded x_i = 0x1000_0000+i, start, out_ready=1 -> 32 words in order, out_idx 0..31, out_data matches, done 64 cycles after start.
- out_ready low for 5 cycles while word idx 7 valid -> out_data=0x1000_0007 held stable, no skip or duplicate.
- abort asserted in SEND of idx 10 -> out_valid drops next edge, busy=0, no done; new start dumps from idx 0.
- start pulsed again during dump at idx 3 -> ignored, sequence continues 4..31 unchanged.
- rst asserted mid-dump at idx 20 -> all outputs zero immediately; after release, IDLE, busy=0.
- REG_DUMP_CHECKSUM_EN, all x_i = 0xFFFF_FFFF except x0=0 -> 33rd word 0xFFFF_FFFF (31 ones XORed), out_last only on it.
